// File: rtl/cfo_emulator_sequencer.sv
// Sequencer for the CFO emulator switch: timed Heartbeat markers with incrementing
// event window tags, each optionally followed by a DataReq.
module cfo_emulator_sequencer #(
    parameter int unsigned  PERIOD_W = 16,
    parameter int unsigned  CNT_W    = 32,
    localparam int unsigned TAG_W    = 48,
    localparam int unsigned MODE_W   = 32,
    localparam int unsigned TYPE_W   = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                emul_enable_req,
    input  logic                emul_start,
    input  logic                emul_stop,
    input  logic [PERIOD_W-1:0] ewt_period,
    input  logic [CNT_W-1:0]    num_ewt,
    input  logic [TAG_W-1:0]    start_ewt,
    input  logic [MODE_W-1:0]   event_mode,
    input  logic                datareq_en,
    input  logic [PERIOD_W-1:0] datareq_delay,
    input  logic                marker_ack,
    output logic                cfo_emul_en,
    output logic                cfo_emul_MARKER_SEL,
    output logic [TYPE_W-1:0]   cfo_emul_PACKET_TYPE,
    output logic [MODE_W-1:0]   cfo_emul_EVENT_MODE,
    output logic [TAG_W-1:0]    cfo_emul_EVENT_WINDOW_TAG,
    output logic                busy,
    output logic [CNT_W-1:0]    ewt_sent_count,
    output logic                overrun
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_TICK = 3'd1,
        S_SEND_HB   = 3'd2,
        S_WAIT_DR   = 3'd3,
        S_SEND_DR   = 3'd4
    } state_e;

    state_e state_q, state_d;

    logic                en_q, en_d;
    logic                sel_q, sel_d;
    logic [TYPE_W-1:0]   type_q, type_d;
    logic [MODE_W-1:0]   mode_q, mode_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic                busy_q, busy_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                overrun_q, overrun_d;
    logic                pending_q, pending_d;
    logic                stop_pending_q, stop_pending_d;
    logic [PERIOD_W-1:0] timer_q, timer_d;
    logic [PERIOD_W-1:0] dly_q, dly_d;

    logic                start_c;
    logic                stop_req_c;
    logic                stop_now_c;
    logic                ack_c;
    logic                tick_c;
    logic                last_c;
    logic [PERIOD_W-1:0] reload_c;
    logic [CNT_W-1:0]    count_inc_c;

    assign start_c     = (state_q == S_IDLE) && emul_start && emul_enable_req;
    assign stop_req_c  = emul_stop || !emul_enable_req;
    assign stop_now_c  = stop_pending_q || stop_req_c;
    assign ack_c       = marker_ack && sel_q;
    assign tick_c      = (state_q != S_IDLE) && (timer_q == '0);
    assign reload_c    = (ewt_period == '0) ? '0 : ewt_period - PERIOD_W'(1);
    assign count_inc_c = count_q + CNT_W'(1);
    assign last_c      = (num_ewt != '0) && (count_inc_c == num_ewt);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: stop is honoured immediately while waiting, only after ack while sending.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_c) state_d = S_WAIT_TICK;
            end
            S_WAIT_TICK: begin
                if (stop_now_c)                state_d = S_IDLE;
                else if (pending_q || tick_c)  state_d = S_SEND_HB;
            end
            S_SEND_HB: begin
                if (ack_c) begin
                    if (datareq_en)                state_d = S_WAIT_DR;
                    else if (last_c || stop_now_c) state_d = S_IDLE;
                    else                           state_d = S_WAIT_TICK;
                end
            end
            S_WAIT_DR: begin
                if (stop_now_c)                    state_d = S_IDLE;
                else if (dly_q <= PERIOD_W'(1))    state_d = S_SEND_DR;
            end
            S_SEND_DR: begin
                if (ack_c) begin
                    if (last_c || stop_now_c) state_d = S_IDLE;
                    else                      state_d = S_WAIT_TICK;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        en_d           = en_q;
        type_d         = type_q;
        mode_d         = mode_q;
        tag_d          = tag_q;
        count_d        = count_q;
        overrun_d      = overrun_q;
        pending_d      = pending_q;
        stop_pending_d = stop_pending_q;
        timer_d        = timer_q;
        dly_d          = dly_q;
        sel_d          = (state_d == S_SEND_HB) || (state_d == S_SEND_DR);
        busy_d         = (state_d != S_IDLE);

        if (start_c) begin
            en_d           = 1'b1;
            tag_d          = start_ewt;
            count_d        = '0;
            overrun_d      = 1'b0;
            timer_d        = reload_c;
            pending_d      = 1'b0;
            stop_pending_d = 1'b0;
        end

        // One-deep tick queue: a second tick while one is pending is dropped and flagged.
        if (state_q != S_IDLE) begin
            timer_d = tick_c ? reload_c : timer_q - PERIOD_W'(1);
            if (stop_req_c) stop_pending_d = 1'b1;
            if ((state_q == S_WAIT_TICK) && !stop_now_c && (pending_q || tick_c)) begin
                pending_d = pending_q && tick_c;
            end else if (tick_c) begin
                if (pending_q) overrun_d = 1'b1;
                else           pending_d = 1'b1;
            end
        end

        if (((state_q == S_SEND_HB) && ack_c && !datareq_en) ||
            ((state_q == S_SEND_DR) && ack_c)) begin
            tag_d   = tag_q + TAG_W'(1);
            count_d = count_inc_c;
        end

        if ((state_q == S_SEND_HB) && ack_c) begin
            dly_d = datareq_delay;
        end else if ((state_q == S_WAIT_DR) && (dly_q != '0)) begin
            dly_d = dly_q - PERIOD_W'(1);
        end

        if ((state_d == S_SEND_HB) && (state_q != S_SEND_HB)) begin
            type_d = TYPE_W'(1);
            mode_d = event_mode;
        end
        if ((state_d == S_SEND_DR) && (state_q != S_SEND_DR)) begin
            type_d = TYPE_W'(2);
        end

        if ((state_q != S_IDLE) && (state_d == S_IDLE)) begin
            en_d           = 1'b0;
            pending_d      = 1'b0;
            stop_pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en_q           <= 1'b0;
            sel_q          <= 1'b0;
            type_q         <= '0;
            mode_q         <= '0;
            tag_q          <= '0;
            busy_q         <= 1'b0;
            count_q        <= '0;
            overrun_q      <= 1'b0;
            pending_q      <= 1'b0;
            stop_pending_q <= 1'b0;
            timer_q        <= '0;
            dly_q          <= '0;
        end else begin
            en_q           <= en_d;
            sel_q          <= sel_d;
            type_q         <= type_d;
            mode_q         <= mode_d;
            tag_q          <= tag_d;
            busy_q         <= busy_d;
            count_q        <= count_d;
            overrun_q      <= overrun_d;
            pending_q      <= pending_d;
            stop_pending_q <= stop_pending_d;
            timer_q        <= timer_d;
            dly_q          <= dly_d;
        end
    end

    assign cfo_emul_en               = en_q;
    assign cfo_emul_MARKER_SEL       = sel_q;
    assign cfo_emul_PACKET_TYPE      = type_q;
    assign cfo_emul_EVENT_MODE       = mode_q;
    assign cfo_emul_EVENT_WINDOW_TAG = tag_q;
    assign busy                      = busy_q;
    assign ewt_sent_count            = count_q;
    assign overrun                   = overrun_q;

endmodule

// File: tb/tb_cfo_emulator_sequencer.sv
// Self-checking bench for cfo_emulator_sequencer: scoreboarded marker stream with an
// auto-acking transmitter model.
module tb_cfo_emulator_sequencer;

    typedef struct packed {
        logic [3:0]  typ;
        logic [47:0] tag;
        logic [31:0] mode;
    } mk_t;

    logic        clk             = 1'b0;
    logic        reset_n         = 1'b0;
    logic        emul_enable_req = 1'b1;
    logic        emul_start      = 1'b0;
    logic        emul_stop       = 1'b0;
    logic [15:0] ewt_period      = '0;
    logic [31:0] num_ewt         = '0;
    logic [47:0] start_ewt       = '0;
    logic [31:0] event_mode      = '0;
    logic        datareq_en      = 1'b0;
    logic [15:0] datareq_delay   = '0;
    logic        marker_ack      = 1'b0;

    logic        cfo_emul_en;
    logic        cfo_emul_MARKER_SEL;
    logic [3:0]  cfo_emul_PACKET_TYPE;
    logic [31:0] cfo_emul_EVENT_MODE;
    logic [47:0] cfo_emul_EVENT_WINDOW_TAG;
    logic        busy;
    logic [31:0] ewt_sent_count;
    logic        overrun;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   ack_lat = 0;
    bit   ack_auto = 1'b1;
    int   hold = 0;
    int   last_rise = 0;
    logic sel_prev = 1'b0;
    mk_t  exp_q[$];
    mk_t  obs_q[$];
    int   rise_q[$];

    cfo_emulator_sequencer dut (
        .clk                       (clk),
        .reset_n                   (reset_n),
        .emul_enable_req           (emul_enable_req),
        .emul_start                (emul_start),
        .emul_stop                 (emul_stop),
        .ewt_period                (ewt_period),
        .num_ewt                   (num_ewt),
        .start_ewt                 (start_ewt),
        .event_mode                (event_mode),
        .datareq_en                (datareq_en),
        .datareq_delay             (datareq_delay),
        .marker_ack                (marker_ack),
        .cfo_emul_en               (cfo_emul_en),
        .cfo_emul_MARKER_SEL       (cfo_emul_MARKER_SEL),
        .cfo_emul_PACKET_TYPE      (cfo_emul_PACKET_TYPE),
        .cfo_emul_EVENT_MODE       (cfo_emul_EVENT_MODE),
        .cfo_emul_EVENT_WINDOW_TAG (cfo_emul_EVENT_WINDOW_TAG),
        .busy                      (busy),
        .ewt_sent_count            (ewt_sent_count),
        .overrun                   (overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter model: acks a held request after ack_lat extra cycles, logs accepted markers.
    always @(negedge clk) begin
        mk_t m;
        if (cfo_emul_MARKER_SEL && !sel_prev) last_rise = cyc;
        sel_prev = cfo_emul_MARKER_SEL;
        if (marker_ack) begin
            marker_ack = 1'b0;
        end else if (ack_auto && cfo_emul_MARKER_SEL) begin
            if (hold >= ack_lat) begin
                marker_ack = 1'b1;
                hold = 0;
                m.typ  = cfo_emul_PACKET_TYPE;
                m.tag  = cfo_emul_EVENT_WINDOW_TAG;
                m.mode = cfo_emul_EVENT_MODE;
                obs_q.push_back(m);
                rise_q.push_back(last_rise);
            end else begin
                hold++;
            end
        end else begin
            hold = 0;
        end
    end

    task automatic tick_n(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_start();
        emul_start = 1'b1;
        tick_n(1);
        start_cyc  = cyc;
        emul_start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit to);
        to = 1'b1;
        for (int i = 0; i < budget; i++) begin
            tick_n(1);
            if (!busy) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic configure(input logic [15:0] p, input logic [31:0] n, input logic [47:0] s,
                             input logic [31:0] m, input logic de, input logic [15:0] d);
        ewt_period    = p;
        num_ewt       = n;
        start_ewt     = s;
        event_mode    = m;
        datareq_en    = de;
        datareq_delay = d;
        exp_q.delete();
        obs_q.delete();
        rise_q.delete();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick_n(2);
        n_cmp++; if (cfo_emul_en !== 1'b0) begin n_bad++; $display("FAIL reset_en got=%b exp=0", cfo_emul_en); end
        n_cmp++; if (cfo_emul_MARKER_SEL !== 1'b0) begin n_bad++; $display("FAIL reset_sel got=%b exp=0", cfo_emul_MARKER_SEL); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (cfo_emul_EVENT_WINDOW_TAG !== 48'h0) begin n_bad++; $display("FAIL reset_tag got=%h exp=0", cfo_emul_EVENT_WINDOW_TAG); end
        n_cmp++; if ({cfo_emul_PACKET_TYPE, cfo_emul_EVENT_MODE, ewt_sent_count, overrun} !== 69'h0) begin
            n_bad++; $display("FAIL reset_misc got type=%h mode=%h count=%0d ovr=%b exp all 0",
                              cfo_emul_PACKET_TYPE, cfo_emul_EVENT_MODE, ewt_sent_count, overrun);
        end
        reset_n = 1'b1;
        tick_n(1);
    endtask

    task automatic test_hb_basic();
        mk_t e, o;
        bit  to;
        int  exp_r;
        configure(16'd4, 32'd3, 48'h10, 32'hA5A5_0001, 1'b0, 16'd0);
        ack_lat = 0;
        for (int i = 0; i < 3; i++) exp_q.push_back(mk_t'{4'd1, 48'h10 + 48'(i), 32'hA5A5_0001});
        do_start();
        n_cmp++; if (cfo_emul_en !== 1'b1) begin n_bad++; $display("FAIL hb_start_en got=%b exp=1", cfo_emul_en); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL hb_start_busy got=%b exp=1", busy); end
        n_cmp++; if (cfo_emul_EVENT_WINDOW_TAG !== 48'h10) begin n_bad++; $display("FAIL hb_start_tag got=%h exp=10", cfo_emul_EVENT_WINDOW_TAG); end
        wait_idle(60, to);
        n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL hb_timeout got=busy exp=idle"); end
        n_cmp++; if (cfo_emul_en !== 1'b0) begin n_bad++; $display("FAIL hb_end_en got=%b exp=0", cfo_emul_en); end
        n_cmp++; if (ewt_sent_count !== 32'd3) begin n_bad++; $display("FAIL hb_count got=%0d exp=3", ewt_sent_count); end
        n_cmp++;
        if (rise_q.size() !== 3) begin
            n_bad++; $display("FAIL hb_rise_count got=%0d exp=3", rise_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                exp_r = (i == 0) ? start_cyc + 4 : rise_q[i-1] + 4;
                n_cmp++; if (rise_q[i] !== exp_r) begin n_bad++; $display("FAIL hb_spacing%0d got=%0d exp=%0d", i, rise_q[i], exp_r); end
            end
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin n_bad++; $display("FAIL hb_marker missing exp type=%0d tag=%h", e.typ, e.tag); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_bad++; $display("FAIL hb_marker got type=%0d tag=%h mode=%h exp type=%0d tag=%h mode=%h", o.typ, o.tag, o.mode, e.typ, e.tag, e.mode); end
            end
        end
        n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL hb_extra got=%0d exp=0", obs_q.size()); end
    endtask

    task automatic test_datareq();
        mk_t e, o;
        bit  to;
        configure(16'd10, 32'd2, 48'h2000, 32'h0000_BEEF, 1'b1, 16'd2);
        ack_lat = 0;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(mk_t'{4'd1, 48'h2000 + 48'(i), 32'h0000_BEEF});
            exp_q.push_back(mk_t'{4'd2, 48'h2000 + 48'(i), 32'h0000_BEEF});
        end
        do_start();
        wait_idle(100, to);
        n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL dr_timeout got=busy exp=idle"); end
        n_cmp++; if (ewt_sent_count !== 32'd2) begin n_bad++; $display("FAIL dr_count got=%0d exp=2", ewt_sent_count); end
        n_cmp++;
        if (rise_q.size() !== 4) begin
            n_bad++; $display("FAIL dr_rise_count got=%0d exp=4", rise_q.size());
        end else begin
            n_cmp++; if (rise_q[1] - rise_q[0] !== 3) begin n_bad++; $display("FAIL dr_delay0 got=%0d exp=3", rise_q[1] - rise_q[0]); end
            n_cmp++; if (rise_q[3] - rise_q[2] !== 3) begin n_bad++; $display("FAIL dr_delay1 got=%0d exp=3", rise_q[3] - rise_q[2]); end
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin n_bad++; $display("FAIL dr_marker missing exp type=%0d tag=%h", e.typ, e.tag); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_bad++; $display("FAIL dr_marker got type=%0d tag=%h mode=%h exp type=%0d tag=%h mode=%h", o.typ, o.tag, o.mode, e.typ, e.tag, e.mode); end
            end
        end
        n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL dr_extra got=%0d exp=0", obs_q.size()); end
    endtask

    task automatic test_tag_wrap();
        mk_t e, o;
        bit  to;
        configure(16'd3, 32'd2, 48'hFFFF_FFFF_FFFF, 32'h1234_5678, 1'b0, 16'd0);
        ack_lat = 0;
        exp_q.push_back(mk_t'{4'd1, 48'hFFFF_FFFF_FFFF, 32'h1234_5678});
        exp_q.push_back(mk_t'{4'd1, 48'h0, 32'h1234_5678});
        do_start();
        wait_idle(50, to);
        n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL wrap_timeout got=busy exp=idle"); end
        n_cmp++; if (ewt_sent_count !== 32'd2) begin n_bad++; $display("FAIL wrap_count got=%0d exp=2", ewt_sent_count); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin n_bad++; $display("FAIL wrap_marker missing exp type=%0d tag=%h", e.typ, e.tag); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_bad++; $display("FAIL wrap_marker got type=%0d tag=%h exp type=%0d tag=%h", o.typ, o.tag, e.typ, e.tag); end
            end
        end
        n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL wrap_extra got=%0d exp=0", obs_q.size()); end
    endtask

    task automatic test_overrun();
        mk_t e, o;
        bit  to;
        configure(16'd2, 32'd1, 48'h55, 32'hCAFE_0004, 1'b0, 16'd0);
        ack_lat = 6;
        exp_q.push_back(mk_t'{4'd1, 48'h55, 32'hCAFE_0004});
        do_start();
        tick_n(7);
        n_cmp++; if (cfo_emul_MARKER_SEL !== 1'b1) begin n_bad++; $display("FAIL ovr_sel_held got=%b exp=1", cfo_emul_MARKER_SEL); end
        n_cmp++; if ({cfo_emul_PACKET_TYPE, cfo_emul_EVENT_WINDOW_TAG, cfo_emul_EVENT_MODE} !== {4'd1, 48'h55, 32'hCAFE_0004}) begin
            n_bad++; $display("FAIL ovr_fields got type=%0d tag=%h mode=%h exp type=1 tag=55 mode=cafe0004",
                              cfo_emul_PACKET_TYPE, cfo_emul_EVENT_WINDOW_TAG, cfo_emul_EVENT_MODE);
        end
        n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_flag got=%b exp=1", overrun); end
        wait_idle(50, to);
        n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL ovr_timeout got=busy exp=idle"); end
        n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end
        n_cmp++; if (ewt_sent_count !== 32'd1) begin n_bad++; $display("FAIL ovr_count got=%0d exp=1", ewt_sent_count); end
        ack_lat = 0;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin n_bad++; $display("FAIL ovr_marker missing exp tag=%h", e.tag); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_bad++; $display("FAIL ovr_marker got type=%0d tag=%h exp type=%0d tag=%h", o.typ, o.tag, e.typ, e.tag); end
            end
        end
        n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL ovr_extra got=%0d exp=0", obs_q.size()); end
    endtask

    task automatic test_stop();
        mk_t e, o;
        int  r;
        int  en_fall;
        configure(16'd6, 32'd0, 48'h700, 32'h0000_0077, 1'b0, 16'd0);
        ack_lat = 2;
        exp_q.push_back(mk_t'{4'd1, 48'h700, 32'h0000_0077});
        emul_enable_req = 1'b0;
        emul_start = 1'b1;
        tick_n(1);
        emul_start = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL stop_gated_start got busy=%b exp=0", busy); end
        emul_enable_req = 1'b1;
        do_start();
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL stop_ovr_clear got=%b exp=0", overrun); end
        r = -1;
        for (int i = 0; i < 20; i++) begin
            tick_n(1);
            if (cfo_emul_MARKER_SEL) begin r = cyc; break; end
        end
        n_cmp++;
        if (r < 0) begin
            n_bad++; $display("FAIL stop_hb_seen got=none exp=request");
        end else begin
            emul_stop = 1'b1;
            tick_n(1);
            emul_stop = 1'b0;
            en_fall = -1;
            for (int i = 0; i < 10; i++) begin
                if (!cfo_emul_en) begin en_fall = cyc; break; end
                tick_n(1);
            end
            n_cmp++; if (en_fall !== r + 3) begin n_bad++; $display("FAIL stop_en_fall got=%0d exp=%0d", en_fall, r + 3); end
            n_cmp++; if (ewt_sent_count !== 32'd1) begin n_bad++; $display("FAIL stop_count got=%0d exp=1", ewt_sent_count); end
            n_cmp++; if ({busy, cfo_emul_MARKER_SEL} !== 2'b00) begin n_bad++; $display("FAIL stop_idle got busy=%b sel=%b exp 0 0", busy, cfo_emul_MARKER_SEL); end
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin n_bad++; $display("FAIL stop_marker missing exp tag=%h", e.tag); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_bad++; $display("FAIL stop_marker got type=%0d tag=%h exp type=%0d tag=%h", o.typ, o.tag, e.typ, e.tag); end
            end
        end
        n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL stop_extra got=%0d exp=0", obs_q.size()); end
        configure(16'd20, 32'd0, 48'h800, 32'h0000_0088, 1'b0, 16'd0);
        ack_lat = 0;
        do_start();
        tick_n(3);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL stopw_busy got=%b exp=1", busy); end
        emul_stop = 1'b1;
        tick_n(1);
        emul_stop = 1'b0;
        n_cmp++; if ({busy, cfo_emul_en} !== 2'b00) begin n_bad++; $display("FAIL stopw_idle got busy=%b en=%b exp 0 0", busy, cfo_emul_en); end
        n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL stopw_markers got=%0d exp=0", obs_q.size()); end
    endtask

    task automatic test_reset_mid_dr();
        mk_t e, o;
        bit  to;
        bit  seen;
        configure(16'd4, 32'd0, 48'h100, 32'h0000_0606, 1'b1, 16'd1);
        ack_lat = 0;
        exp_q.push_back(mk_t'{4'd1, 48'h100, 32'h0000_0606});
        do_start();
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick_n(1);
            if (obs_q.size() != 0) begin seen = 1'b1; break; end
        end
        ack_auto = 1'b0;
        n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL rst_hb_ack got=none exp=ack"); end
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick_n(1);
            if (cfo_emul_MARKER_SEL && (cfo_emul_PACKET_TYPE == 4'd2)) begin seen = 1'b1; break; end
        end
        n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL rst_dr_req got=none exp=request"); end
        reset_n = 1'b0;
        #1;
        n_cmp++; if ({cfo_emul_MARKER_SEL, cfo_emul_en, busy} !== 3'b000) begin
            n_bad++; $display("FAIL rst_async_ctrl got sel=%b en=%b busy=%b exp 0 0 0", cfo_emul_MARKER_SEL, cfo_emul_en, busy);
        end
        n_cmp++; if ({cfo_emul_PACKET_TYPE, cfo_emul_EVENT_WINDOW_TAG, cfo_emul_EVENT_MODE} !== 84'h0) begin
            n_bad++; $display("FAIL rst_async_fields got type=%0d tag=%h mode=%h exp all 0",
                              cfo_emul_PACKET_TYPE, cfo_emul_EVENT_WINDOW_TAG, cfo_emul_EVENT_MODE);
        end
        tick_n(2);
        reset_n  = 1'b1;
        ack_auto = 1'b1;
        tick_n(1);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin n_bad++; $display("FAIL rst_marker missing exp tag=%h", e.tag); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_bad++; $display("FAIL rst_marker got type=%0d tag=%h exp type=%0d tag=%h", o.typ, o.tag, e.typ, e.tag); end
            end
        end
        n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL rst_extra got=%0d exp=0", obs_q.size()); end
        configure(16'd4, 32'd1, 48'h200, 32'h0000_0707, 1'b0, 16'd0);
        exp_q.push_back(mk_t'{4'd1, 48'h200, 32'h0000_0707});
        do_start();
        n_cmp++; if (cfo_emul_EVENT_WINDOW_TAG !== 48'h200) begin n_bad++; $display("FAIL rst_restart_tag got=%h exp=200", cfo_emul_EVENT_WINDOW_TAG); end
        wait_idle(50, to);
        n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL rst_timeout got=busy exp=idle"); end
        n_cmp++; if (ewt_sent_count !== 32'd1) begin n_bad++; $display("FAIL rst_count got=%0d exp=1", ewt_sent_count); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin n_bad++; $display("FAIL rst2_marker missing exp tag=%h", e.tag); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_bad++; $display("FAIL rst2_marker got type=%0d tag=%h exp type=%0d tag=%h", o.typ, o.tag, e.typ, e.tag); end
            end
        end
        n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL rst2_extra got=%0d exp=0", obs_q.size()); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_hb_basic();
        test_datareq();
        test_tag_wrap();
        test_overrun();
        test_stop();
        test_reset_mid_dr();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
